// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared FSM state type and counter width helper for the fetch buffer
package fetch_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    // Occupancy counters must hold the value DEPTH itself, hence one extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - single-clock FIFO with flush, used for fetch tags and the instruction queue
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CW = cnt_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_buffer_unit.sv
// rtl/fetch_buffer_unit.sv - instruction fetch unit with credit-limited requests and a redirect-flushable queue
module fetch_buffer_unit
    import fetch_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int DEPTH        = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDRESS_BITS-1:0] program_address,
    input  logic                    redirect,
    input  logic [ADDRESS_BITS-1:0] redirect_target,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDRESS_BITS-1:0] mem_req_addr,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [DATA_WIDTH-1:0]   instruction,
    output logic [ADDRESS_BITS-1:0] inst_PC,
    input  logic                    report
);
    localparam int CW = cnt_width(DEPTH);
    localparam int QW = ADDRESS_BITS + DATA_WIDTH;

    fetch_state_e            state;
    logic [ADDRESS_BITS-1:0] pc;
    logic [CW-1:0]           outstanding;
    logic [CW-1:0]           drop_count;
    logic [CW-1:0]           q_count;
    logic [CW-1:0]           tag_count;
    logic [CW:0]             in_use;
    logic [31:0]             fetched;
    logic [31:0]             dropped;
    logic                    flush_evt;
    logic                    req_fire;
    logic                    resp_seen;
    logic                    resp_keep;
    logic                    tag_pop;
    logic                    tag_empty;
    logic                    q_empty;
    logic                    q_pop;
    logic [ADDRESS_BITS-1:0] tag_head;
    logic [QW-1:0]           q_head;

    // Start behaves as a redirect when already running, so both share one flush path.
    assign flush_evt     = start || (redirect && state == RUN);
    assign in_use        = {1'b0, outstanding} + {1'b0, q_count};
    assign mem_req_valid = (state == RUN) && (in_use < (CW+1)'(DEPTH)) && !redirect && !start;
    assign mem_req_addr  = pc >> 2;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // Tags of responses owed to drop_count are discarded at flush, so only kept responses pop a tag.
    assign resp_seen = mem_resp_valid && (outstanding != '0);
    assign tag_pop   = resp_seen && (drop_count == '0);
    assign resp_keep = tag_pop && !flush_evt;

    assign inst_valid  = !q_empty;
    assign q_pop       = inst_valid && inst_ready;
    assign instruction = inst_valid ? q_head[DATA_WIDTH-1:0] : '0;
    assign inst_PC     = inst_valid ? q_head[QW-1:DATA_WIDTH] : '0;

    fetch_fifo #(.WIDTH(ADDRESS_BITS), .DEPTH(DEPTH)) u_tags (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush_evt),
        .push      (req_fire),
        .push_data (pc),
        .pop       (tag_pop),
        .head      (tag_head),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    fetch_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush_evt),
        .push      (resp_keep),
        .push_data ({tag_head, mem_resp_data}),
        .pop       (q_pop),
        .head      (q_head),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            outstanding <= '0;
            drop_count  <= '0;
            fetched     <= '0;
            dropped     <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_seen);
            if (resp_keep)              fetched <= fetched + 32'd1;
            if (resp_seen && !resp_keep) dropped <= dropped + 32'd1;

            if (start) begin
                state <= RUN;
                pc    <= program_address;
            end else if (flush_evt) begin
                pc <= redirect_target;
            end else if (req_fire) begin
                pc <= pc + ADDRESS_BITS'(4);
            end

            if (flush_evt)
                drop_count <= outstanding - CW'(resp_seen);
            else if (resp_seen && drop_count != '0)
                drop_count <= drop_count - CW'(1);
        end
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(mem_resp_valid && drop_count == '0 && tag_empty))
                else $error("core %0d: memory response with no fetch in flight", CORE);
            if (report)
                $info("core %0d fetch: state=%s pc=%h outstanding=%0d drop=%0d tags=%0d queue=%0d fetched=%0d dropped=%0d",
                      CORE, state.name(), pc, outstanding, drop_count, tag_count, q_count, fetched, dropped);
        end
    end
`endif

endmodule

// File: doc/fetch_buffer_unit.md
FETCH_BUFFER_UNIT -- requirements
Module: fetch_buffer_unit

Interface
REQ-001 Parameter CORE, default 0: core ID printed in reports.
REQ-002 Parameter DATA_WIDTH, default 32: instruction width.
REQ-003 Parameter ADDRESS_BITS, default 20: PC width, in bytes.
REQ-004 Parameter DEPTH, default 4: instruction queue entries and maximum in-flight requests; power of two, at least 2.
REQ-005 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port start, input, 1: begin fetching at program_address.
REQ-008 Port program_address, input, ADDRESS_BITS: start byte address.
REQ-009 Port redirect, input, 1: control-flow change (branch, JAL or JALR resolved upstream).
REQ-010 Port redirect_target, input, ADDRESS_BITS: new byte PC.
REQ-011 Port mem_req_valid, output, 1: fetch request.
REQ-012 Port mem_req_ready, input, 1: memory accepts the request.
REQ-013 Port mem_req_addr, output, ADDRESS_BITS: word address, equal to PC >> 2.
REQ-014 Port mem_resp_valid, input, 1: in-order response.
REQ-015 Port mem_resp_data, input, DATA_WIDTH: response instruction.
REQ-016 Port inst_valid, output, 1: queue head is valid.
REQ-017 Port inst_ready, input, 1: decode consumes the head.
REQ-018 Port instruction, output, DATA_WIDTH: head instruction.
REQ-019 Port inst_PC, output, ADDRESS_BITS: byte PC of the head.
REQ-020 Port report, input, 1: print a status block that cycle (simulation only).

Function
REQ-021 The FSM SHALL have two states, IDLE and RUN: start moves it to RUN from either state and loads PC <= program_address.
REQ-022 In RUN, mem_req_valid SHALL equal (outstanding + queue_count < DEPTH) && !redirect && !start.
REQ-023 A request SHALL fire when mem_req_valid && mem_req_ready; on firing, the PC is pushed into the in-flight tag FIFO, outstanding increments, and PC <= PC + 4, wrapping modulo 2^ADDRESS_BITS.
REQ-024 Each mem_resp_valid SHALL pop one tag and decrement outstanding; a response with mem_resp_valid and an empty tag FIFO is a protocol error and SHALL be flagged in simulation.
REQ-025 A popped response SHALL push {tag, mem_resp_data} into the queue when drop_count == 0; otherwise the response is discarded and drop_count decrements.
REQ-026 Latency: a response accepted in cycle N SHALL appear at the head with inst_valid=1 in cycle N+1 if the queue was empty.
REQ-027 The queue SHALL pop when inst_valid && inst_ready; push and pop in the same cycle are both honoured.
REQ-028 Credit accounting SHALL guarantee the queue never overflows, so no response is ever back-pressured.
REQ-029 On redirect (in RUN), the block SHALL: flush the queue (inst_valid=0 next cycle); set drop_count <= outstanding minus any response popped that cycle; set PC <= redirect_target; clear the tag FIFO of entries already covered by drop_count.
REQ-030 On redirect, a response arriving in the same cycle SHALL be discarded, and any head consumed in that cycle is still considered delivered.
REQ-031 Start together with redirect: start SHALL win; outstanding responses SHALL be dropped, as for a redirect.
REQ-032 While drop_count > 0, requests SHALL still issue, subject to REQ-022.
REQ-033 Two 32-bit counters SHALL be kept: fetched (pushes) and dropped (discards); both are printed on report.

Reset
REQ-034 Reset SHALL set: state=IDLE, PC=0, outstanding=0, drop_count=0, both FIFOs empty, counters=0.
REQ-035 During reset: mem_req_valid=0, inst_valid=0, instruction=0, inst_PC=0, mem_req_addr=0.
REQ-036 Reset asserted mid-operation SHALL abandon all in-flight state; memory is reset by the same signal.

Structure
REQ-037 Shared package fetch_pkg SHALL hold the FSM state enum and the width helper for counters: clog2(DEPTH)+1 bits.
REQ-038 Sub-module fetch_fifo (synchronous, parametrised width and depth, with a flush input) SHALL be instantiated twice: once for tags, once for the queue.

Verification
REQ-039 Basic fetch: start with program_address=0x100, ready=1, one-cycle memory -> inst_PC sequence 0x100, 0x104, 0x108 with matching data, one per cycle.
REQ-040 Back-pressure: inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests, then mem_req_valid=0; no data lost after release.
REQ-041 Redirect with 3 requests outstanding, target=0x2000 -> next 3 responses dropped, dropped=3, first delivered inst_PC=0x2000.
REQ-042 Redirect in the same cycle as a response and a head pop -> the response is dropped, the popped head is delivered once, and drop_count equals the remaining outstanding.
REQ-043 PC wrap: program_address=0xFFFFC with ADDRESS_BITS=20 -> inst_PC sequence 0xFFFFC, 0x00000.
REQ-044 Async reset asserted mid-run, between clock edges -> all outputs are 0 immediately; after a restart, no stale instruction is delivered.
